// File: rtl/dmem_frame_streamer.sv
// Streams a frame out of data memory in raster order, one pixel per beat.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a frame / cancel the frame in progress
//   busy, done          streaming indicator / end-of-frame pulse
//   mem_addr, mem_rd    data-memory read port (1-cycle read latency)
//   m_valid, m_ready    output beat handshake
//   m_data              pixel value, clamped to 8 bits
//   m_first, m_last     pixel (0,0) marker / end-of-row marker
module dmem_frame_streamer #(
  parameter int unsigned IMG_W     = 360,
  parameter int unsigned IMG_H     = 360,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_first,
  output logic        m_last
);

  localparam int unsigned CW = 17;
  localparam logic [CW-1:0] X_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(IMG_H - 1);
  localparam logic [31:0]   BASE  = 32'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rx_q, rx_d, ry_q, ry_d;
  logic [CW-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [31:0]     addr_q, addr_d;
  logic            outstanding_q, outstanding_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [7:0]      fifo0_q, fifo0_d, fifo1_q, fifo1_d;

  logic [7:0]      pix_c;
  logic            hs, pop, push, issue;
  logic [1:0]      cnt_mid;

  // Saturate the 32-bit memory word to a pixel.
  assign pix_c = (mem_rd > 32'd255) ? 8'hFF : mem_rd[7:0];

  // The in-flight read is presented directly when the FIFO is empty, so the
  // first pixel is valid the cycle its read data returns.
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DRAIN) && (fifo_cnt_q == 2'd0) && !outstanding_q;
  assign m_valid  = (fifo_cnt_q != 2'd0) || outstanding_q;
  assign m_data   = (fifo_cnt_q != 2'd0) ? fifo0_q : (outstanding_q ? pix_c : 8'h00);
  assign m_first  = m_valid && (ox_q == '0) && (oy_q == '0);
  assign m_last   = m_valid && (ox_q == X_MAX);
  assign mem_addr = addr_q;

  // Next-state: FSM, read issue, FIFO and output counters.
  always_comb begin
    state_d       = state_q;
    rx_d          = rx_q;
    ry_d          = ry_q;
    ox_d          = ox_q;
    oy_d          = oy_q;
    addr_d        = addr_q;
    fifo0_d       = fifo0_q;
    fifo1_d       = fifo1_q;
    hs            = m_valid && m_ready;
    pop           = hs && (fifo_cnt_q != 2'd0);
    // A read consumed straight off the bypass never enters the FIFO.
    push          = outstanding_q && !(hs && (fifo_cnt_q == 2'd0));
    issue         = (state_q == STREAM) && ((fifo_cnt_q + {1'b0, outstanding_q}) < 2'd2);
    outstanding_d = issue;
    cnt_mid       = fifo_cnt_q - {1'b0, pop};

    if (pop) fifo0_d = fifo1_q;
    if (push) begin
      if (cnt_mid == 2'd0) fifo0_d = pix_c;
      else                 fifo1_d = pix_c;
    end
    fifo_cnt_d = cnt_mid + {1'b0, push};

    if (hs) begin
      if (ox_q == X_MAX) begin
        ox_d = '0;
        oy_d = (oy_q == Y_MAX) ? '0 : oy_q + CW'(1);
      end else begin
        ox_d = ox_q + CW'(1);
      end
    end

    if (issue) begin
      addr_d = addr_q + 32'd1;
      if (rx_q == X_MAX) begin
        rx_d = '0;
        ry_d = ry_q + CW'(1);
      end else begin
        rx_d = rx_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        addr_d = BASE;
        if (start) begin
          state_d = STREAM;
          rx_d    = '0;
          ry_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
        end
      end
      STREAM: begin
        if (issue && (rx_q == X_MAX) && (ry_q == Y_MAX)) begin
          state_d = DRAIN;
          addr_d  = BASE;
        end
      end
      DRAIN: begin
        if ((fifo_cnt_q == 2'd0) && !outstanding_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a handshake this cycle.
    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      fifo_cnt_d    = 2'd0;
      outstanding_d = 1'b0;
      addr_d        = BASE;
      ox_d          = '0;
      oy_d          = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rx_q          <= '0;
      ry_q          <= '0;
      ox_q          <= '0;
      oy_q          <= '0;
      addr_q        <= BASE;
      outstanding_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      fifo0_q       <= 8'h00;
      fifo1_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      rx_q          <= rx_d;
      ry_q          <= ry_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo0_q       <= fifo0_d;
      fifo1_q       <= fifo1_d;
    end
  end

endmodule

// File: tb/tb_dmem_frame_streamer.sv
// Directed bench for dmem_frame_streamer with a 4x2 frame; a second instance
// at BASE_ADDR=100 shares all inputs and has its own memory.
module tb_dmem_frame_streamer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, m_ready;
  logic        busy0, done0, m_valid0, m_first0, m_last0;
  logic [31:0] mem_addr0, mem_rd0;
  logic [7:0]  m_data0;
  logic        busy1, done1, m_valid1, m_first1, m_last1;
  logic [31:0] mem_addr1, mem_rd1;
  logic [7:0]  m_data1;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  int total = 0;
  int bad   = 0;

  int          nb, nb1, done_cnt, done_cyc, busy_cnt, stall_bad, ahead_bad, tmo;
  logic [7:0]  bd  [16];
  logic [7:0]  bd1 [16];
  logic        bf  [16];
  logic        bl  [16];
  int          bc  [16];
  logic [31:0] alog [64];
  logic        s_busy, s_done, s_valid, s_first, s_last;
  logic [7:0]  s_data;
  logic [31:0] s_addr0, s_addr1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd0 <= mem0[mem_addr0[7:0]];
    mem_rd1 <= mem1[mem_addr1[7:0]];
  end

  dmem_frame_streamer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy0), .done(done0),
    .mem_addr(mem_addr0), .mem_rd(mem_rd0), .m_valid(m_valid0), .m_ready(m_ready),
    .m_data(m_data0), .m_first(m_first0), .m_last(m_last0));

  dmem_frame_streamer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(100)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy1), .done(done1),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .m_valid(m_valid1), .m_ready(m_ready),
    .m_data(m_data1), .m_first(m_first1), .m_last(m_last1));

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'(i);
      mem1[i] = 32'h0;
    end
    for (int i = 0; i < 8; i++) mem1[100 + i] = 32'h000000A0 + 32'(i);
  endtask

  // Pulse start, then record beats period by period (period 1 follows the start edge).
  // mode: 0 ready held high, 1 ready pattern 1,0,0,1.
  task automatic run_frame(input int mode, input int abort_after, input int start_at,
                           input int rst_at);
    logic prev_stall;
    logic [7:0] prev_data;
    logic abort_pend, restarted;
    nb = 0; nb1 = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    stall_bad = 0; ahead_bad = 0; tmo = 1;
    prev_stall = 1'b0; prev_data = 8'h00; abort_pend = 1'b0; restarted = 1'b0;
    for (int i = 0; i < 64; i++) alog[i] = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b1; m_ready = 1'b1; abort = 1'b0;
    @(negedge clk);
    for (int c = 1; c < 60; c++) begin
      start   = 1'b0;
      abort   = abort_pend;
      m_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (start_at >= 0 && nb == start_at && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (rst_at >= 0 && nb == rst_at) begin
        rst_n = 1'b0;
        #1;
        s_busy = busy0; s_done = done0; s_valid = m_valid0; s_first = m_first0;
        s_last = m_last0; s_data = m_data0; s_addr0 = mem_addr0; s_addr1 = mem_addr1;
        tmo = 0;
        break;
      end
      #1;
      alog[c] = mem_addr1;
      if (busy0) busy_cnt++;
      if (done0) begin
        done_cnt++;
        done_cyc = c;
      end
      if (prev_stall && (!m_valid0 || m_data0 !== prev_data)) stall_bad++;
      if (busy0 && mem_addr0 != 32'd0 && (int'(mem_addr0) - nb) > 2) ahead_bad++;
      if (!busy0 && c > 1) begin
        tmo = 0;
        break;
      end
      if (!abort && m_valid0 && m_ready && nb < 16) begin
        bd[nb] = m_data0; bf[nb] = m_first0; bl[nb] = m_last0; bc[nb] = c;
        nb++;
        if (abort_after >= 0 && nb == abort_after + 1) abort_pend = 1'b1;
      end else if (abort) begin
        abort_pend = 1'b0;
      end
      if (!abort && m_valid1 && m_ready && nb1 < 16) begin
        bd1[nb1] = m_data1;
        nb1++;
      end
      prev_stall = m_valid0 && !m_ready;
      prev_data  = m_data0;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done0); end
    total++; if (m_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid0); end
    total++; if (m_data0 !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", m_data0); end
    total++; if (m_first0 !== 1'b0 || m_last0 !== 1'b0) begin
      bad++; $display("FAIL reset_marks got=%b%b want=00", m_first0, m_last0); end
    total++; if (mem_addr0 !== 32'd0) begin bad++; $display("FAIL reset_addr0 got=%0d want=0", mem_addr0); end
    total++; if (mem_addr1 !== 32'd100) begin bad++; $display("FAIL reset_addr1 got=%0d want=100", mem_addr1); end
  endtask

  task automatic test_basic();
    fill_ramp();
    run_frame(0, -1, -1, -1);
    total++; if (tmo !== 0) begin bad++; $display("FAIL basic_timeout got=%0d want=0", tmo); end
    total++; if (nb !== 8) begin bad++; $display("FAIL basic_beats got=%0d want=8", nb); end
    for (int i = 0; i < 8; i++) begin
      total++; if (bd[i] !== 8'(i)) begin bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, bd[i], 8'(i)); end
      total++; if (bf[i] !== (i == 0)) begin bad++; $display("FAIL basic_first[%0d] got=%b", i, bf[i]); end
      total++; if (bl[i] !== (i == 3 || i == 7)) begin bad++; $display("FAIL basic_last[%0d] got=%b", i, bl[i]); end
      total++; if (bc[i] !== i + 2) begin bad++; $display("FAIL basic_cycle[%0d] got=%0d want=%0d", i, bc[i], i + 2); end
      total++; if (bd1[i] !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL base_data[%0d] got=%h want=%h", i, bd1[i], 8'hA0 + 8'(i)); end
      total++; if (alog[i + 1] !== 32'd100 + 32'(i)) begin
        bad++; $display("FAIL base_addr[%0d] got=%0d want=%0d", i, alog[i + 1], 100 + i); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 10) begin bad++; $display("FAIL basic_done_cyc got=%0d want=10", done_cyc); end
    total++; if (busy_cnt !== 10) begin bad++; $display("FAIL basic_busy_len got=%0d want=10", busy_cnt); end
  endtask

  task automatic test_clamp();
    logic [7:0] exp_c [8];
    fill_ramp();
    mem0[0] = 32'd0;   mem0[1] = 32'd255; mem0[2] = 32'd256; mem0[3] = 32'hFFFFFFFF;
    mem0[4] = 32'd7;   mem0[5] = 32'd300; mem0[6] = 32'd128; mem0[7] = 32'h80000001;
    exp_c[0] = 8'h00; exp_c[1] = 8'hFF; exp_c[2] = 8'hFF; exp_c[3] = 8'hFF;
    exp_c[4] = 8'h07; exp_c[5] = 8'hFF; exp_c[6] = 8'h80; exp_c[7] = 8'hFF;
    run_frame(0, -1, -1, -1);
    total++; if (nb !== 8) begin bad++; $display("FAIL clamp_beats got=%0d want=8", nb); end
    for (int i = 0; i < 8; i++) begin
      total++; if (bd[i] !== exp_c[i]) begin bad++; $display("FAIL clamp_data[%0d] got=%h want=%h", i, bd[i], exp_c[i]); end
    end
  endtask

  task automatic test_backpressure();
    fill_ramp();
    run_frame(1, -1, -1, -1);
    total++; if (tmo !== 0) begin bad++; $display("FAIL bp_timeout got=%0d want=0", tmo); end
    total++; if (nb !== 8) begin bad++; $display("FAIL bp_beats got=%0d want=8", nb); end
    for (int i = 0; i < 8; i++) begin
      total++; if (bd[i] !== 8'(i)) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, bd[i], 8'(i)); end
    end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stall_bad); end
    total++; if (ahead_bad !== 0) begin bad++; $display("FAIL bp_ahead got=%0d want=0", ahead_bad); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_abort();
    fill_ramp();
    run_frame(0, 3, -1, -1);
    total++; if (tmo !== 0) begin bad++; $display("FAIL abort_timeout got=%0d want=0", tmo); end
    total++; if (nb !== 4) begin bad++; $display("FAIL abort_beats got=%0d want=4", nb); end
    total++; if (m_valid0 !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", m_valid0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy0); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
    run_frame(0, -1, -1, -1);
    total++; if (nb !== 8) begin bad++; $display("FAIL abort_restart_beats got=%0d want=8", nb); end
    for (int i = 0; i < 8; i++) begin
      total++; if (bd[i] !== 8'(i) || bf[i] !== (i == 0)) begin
        bad++; $display("FAIL abort_restart[%0d] got=%h/%b want=%h/%b", i, bd[i], bf[i], 8'(i), i == 0); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_restart_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_start_busy();
    fill_ramp();
    run_frame(0, -1, 2, -1);
    total++; if (nb !== 8) begin bad++; $display("FAIL sbusy_beats got=%0d want=8", nb); end
    total++; if (done_cnt !== 1 || busy_cnt !== 10) begin
      bad++; $display("FAIL sbusy_done_busy got=%0d/%0d want=1/10", done_cnt, busy_cnt); end
    repeat (4) @(negedge clk);
    #1;
    total++; if (busy0 !== 1'b0 || m_valid0 !== 1'b0) begin
      bad++; $display("FAIL sbusy_no_second got=%b/%b want=0/0", busy0, m_valid0); end
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    run_frame(0, -1, -1, 5);
    total++; if (s_busy !== 1'b0 || s_done !== 1'b0 || s_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b%b%b want=000", s_busy, s_done, s_valid); end
    total++; if (s_data !== 8'h00 || s_first !== 1'b0 || s_last !== 1'b0) begin
      bad++; $display("FAIL rstmid_data got=%h/%b%b want=00/00", s_data, s_first, s_last); end
    total++; if (s_addr0 !== 32'd0 || s_addr1 !== 32'd100) begin
      bad++; $display("FAIL rstmid_addr got=%0d/%0d want=0/100", s_addr0, s_addr1); end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, -1, -1, -1);
    total++; if (nb !== 8 || done_cnt !== 1) begin
      bad++; $display("FAIL rstmid_frame got=%0d/%0d want=8/1", nb, done_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++; if (bd[i] !== 8'(i)) begin bad++; $display("FAIL rstmid_data[%0d] got=%h want=%h", i, bd[i], 8'(i)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    fill_ramp();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Abort while idle must be harmless.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_clamp();
    test_backpressure();
    test_abort();
    test_start_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_frame_streamer.md
# dmem_frame_streamer

Downstream reader for the data-memory RAM. After the pipeline finishes processing an image into data memory, this block takes over the memory read port and streams the frame out in raster order, one pixel per beat, over a valid/ready interface. The consumer is a display or serial dump sink. It replaces dumping the memory image to a file and works in synthesis as well as simulation.

## Interface
- `IMG_W`, default 360: pixels per row.
- `IMG_H`, default 360: rows per frame; `IMG_W*IMG_H` ≤ 129600.
- `BASE_ADDR`, default 0: word address of pixel (0,0).
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a frame.
- `abort` in 1: cancels the frame in progress.
- `busy` out 1: high while streaming; while high, the CPU must not drive data memory.
- `done` out 1: one-cycle pulse after the last pixel is accepted.
- `mem_addr` out 32: word address to the data-memory read port.
- `mem_rd` in 32: read data, valid exactly 1 cycle after `mem_addr` is issued.
- `m_valid` out 1: pixel beat valid.
- `m_ready` in 1: sink accepts the beat.
- `m_data` out 8: pixel value.
- `m_first` out 1: marks pixel (0,0).
- `m_last` out 1: marks the last pixel of each row.

## Operation
- **FSM states:** IDLE, STREAM, DRAIN.
  - IDLE → STREAM on `start`. This loads the read counters (`rx`, `ry`) = 0 and sets `busy` = 1.
  - STREAM → DRAIN once the read counters have issued address index `IMG_W*IMG_H-1`.
  - DRAIN → IDLE when the FIFO is empty and no read is outstanding. `done` pulses in that same transition cycle and `busy` falls.
- **Read issue:** one read per cycle in STREAM when `fifo_count + outstanding < 2`.
  - `mem_addr = BASE_ADDR + ry*IMG_W + rx`, held in a register and advanced incrementally (no multiplier).
  - `rx` wraps to 0 at `IMG_W-1` and increments `ry`.
- **Memory latency:** fixed at 1 cycle. `outstanding` (0/1) captures `mem_rd` into the 2-entry output FIFO on the cycle after issue.
- **Pixel conversion:** `mem_rd` is treated as unsigned 32-bit. `m_data = (mem_rd > 255) ? 8'hFF : mem_rd[7:0]`.
- **Output counters:** separate counters (`ox`, `oy`) track the pixel at the FIFO head. They advance on each handshake (`m_valid && m_ready`).
  - `m_first = (ox==0 && oy==0)`.
  - `m_last = (ox==IMG_W-1)`.
  - `m_first`/`m_last` travel as FIFO sideband or are derived from `ox`/`oy`; both are valid only when `m_valid` is high.
- **AXI-style handshake:** once `m_valid` is high, `m_data`, `m_first` and `m_last` are held stable until accepted. `m_valid` never drops without a handshake, except on `abort`/reset.
- **Start/abort rules:**
  - `start` while `busy` is ignored.
  - `abort` in STREAM/DRAIN: next cycle the FSM is in IDLE, the FIFO is flushed, `outstanding` is cleared (a late `mem_rd` is discarded), `m_valid`=0, `busy`=0, and no `done` pulse occurs.
  - `abort` has priority over a simultaneous handshake.
  - `abort` in IDLE has no effect.
- **Memory port when idle:** in IDLE, `mem_addr` holds `BASE_ADDR`.

## Timing
- **Reset values:** `busy`=0, `done`=0, `m_valid`=0, `m_data`=0, `m_first`=0, `m_last`=0, `mem_addr`=`BASE_ADDR`; FSM=IDLE; FIFO empty; `outstanding`=0.
- **Start-up latency:** with `start` at cycle 0, the first address is issued at cycle 1, data is captured at cycle 2, and `m_valid`=1 from cycle 2.
- **Throughput:** with `m_ready` held high, one pixel per cycle sustained. A frame of N pixels gives its last handshake at cycle N+1 and the `done` pulse at cycle N+2.
- **Backpressure:** `m_ready`=0 stops issue after the FIFO plus in-flight read reach 2. No pixel is lost or duplicated.
- **Simultaneous push and pop** on a full or empty FIFO is legal; the count is unchanged.
- **Asynchronous reset mid-frame:** all outputs return to reset values immediately.

## Test plan
- **Basic frame:** `IMG_W`=4, `IMG_H`=2, memory[i]=i, `m_ready`=1, `start` → 8 beats with data 0..7; `m_first` on beat 0; `m_last` on beats 3 and 7; `done` one cycle after beat 7; `busy` high for exactly 10 cycles.
- **Clamping:** memory = {0, 255, 256, 0xFFFFFFFF} → `m_data` = 00, FF, FF, FF.
- **Backpressure:** `m_ready` toggles 1,0,0,1 repeatedly → same 0..7 sequence, data stable while stalled, never more than 2 reads ahead of the accepted count.
- **Abort:** `abort` asserted after beat 3 → `m_valid`=0 and `busy`=0 next cycle, no `done`. A following `start` streams beats 0..7 cleanly.
- **Start while busy, and BASE_ADDR:** `start` pulsed at beat 2 is ignored (still 8 beats). With `BASE_ADDR`=100, the addresses issued are 100..107.
- **Reset mid-frame:** `rst_n` low at beat 5 → all outputs are 0 asynchronously and `mem_addr`=`BASE_ADDR`. After release, a new `start` produces a complete frame.
